serial_bit_tx: RTL and testbench

Serialising transmitter that drives a single-wire NRZ bit stream at a programmable bit period. It is the source end of the bit-clock-recovery path: it produces the `signal` line that the recovery block locks onto. It is used for loopback self-test and as the board's pattern source. Parallel bytes enter through a valid/ready handshake, sit in a one-byte holding buffer, and are shifted out MSB first. Each frame starts with an alternating preamble so the receiver sees its minimum edge interval early.

---
 rtl/serial_bit_tx.sv | 143 ++++++++++++++
 tb/tb_serial_bit_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_tx.sv
// Serial NRZ transmitter: one-byte holding buffer, alternating preamble,
// MSB-first data at a programmable bit period.
module serial_bit_tx #(
   parameter int DIV_LEN       = 32,
   parameter int DATA_W        = 8,
   parameter int PREAMBLE_BITS = 16
) (
   input  logic               clk_300M,
   input  logic               rst,
   input  logic [DIV_LEN-1:0] bit_period,
   input  logic               idle_toggle,
   input  logic [DATA_W-1:0]  tx_data,
   input  logic               tx_valid,
   output logic               tx_ready,
   output logic               signal,
   output logic               bit_strobe,
   output logic               busy
);

   localparam int MAXB = (PREAMBLE_BITS > DATA_W) ? PREAMBLE_BITS : DATA_W;
   localparam int BW   = (MAXB > 2) ? $clog2(MAXB) : 1;

   localparam logic [BW-1:0]      PRE_LAST = BW'(PREAMBLE_BITS - 1);
   localparam logic [BW-1:0]      DAT_LAST = BW'(DATA_W - 1);
   localparam logic [DIV_LEN-1:0] P_MIN    = DIV_LEN'(2);
   localparam logic [DIV_LEN-1:0] P_ONE    = DIV_LEN'(1);

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA} state_t;

   state_t              state_q, state_d;
   logic [DIV_LEN-1:0]  cnt_q, cnt_d;
   logic [DIV_LEN-1:0]  per_q, per_d;
   logic                strobe_q;
   logic                sig_q, sig_d;
   logic [DATA_W-1:0]   sh_q, sh_d;
   logic [BW-1:0]       bcnt_q, bcnt_d;
   logic [DATA_W-1:0]   hold_q, hold_d;
   logic                full_q, full_d;
   logic                wrap, accept, load;
   logic [DIV_LEN-1:0]  per_in;

   assign wrap   = (cnt_q == per_q - P_ONE);
   assign accept = tx_valid && !full_q;
   assign per_in = (bit_period < P_MIN) ? P_MIN : bit_period;
   assign cnt_d  = wrap ? '0 : cnt_q + P_ONE;
   assign per_d  = wrap ? per_in : per_q;

   always_ff @(posedge clk_300M or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // An accept on the wrap cycle starts the preamble at this very boundary.
   always_comb begin
      state_d = state_q;
      if (wrap) begin
         unique case (state_q)
            S_IDLE: if (full_q || accept) state_d = S_PRE;
            S_PRE:  if (bcnt_q == PRE_LAST) state_d = S_DATA;
            S_DATA: if (bcnt_q == DAT_LAST && !full_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      sig_d  = sig_q;
      sh_d   = sh_q;
      bcnt_d = bcnt_q;
      hold_d = hold_q;
      full_d = full_q;
      load   = 1'b0;
      if (wrap) begin
         unique case (state_q)
            S_IDLE: begin
               if (full_q || accept) begin
                  sig_d  = 1'b1;
                  bcnt_d = '0;
               end else begin
                  sig_d = idle_toggle ? ~sig_q : 1'b1;
               end
            end
            S_PRE: begin
               if (bcnt_q == PRE_LAST) begin
                  load = 1'b1;
               end else begin
                  bcnt_d = bcnt_q + 1'b1;
                  sig_d  = ~sig_q;
               end
            end
            S_DATA: begin
               if (bcnt_q == DAT_LAST) begin
                  if (full_q) load = 1'b1;
                  else        sig_d = idle_toggle ? ~sig_q : 1'b1;
               end else begin
                  sh_d   = sh_q << 1;
                  sig_d  = sh_d[DATA_W-1];
                  bcnt_d = bcnt_q + 1'b1;
               end
            end
            default: sig_d = 1'b1;
         endcase
      end
      if (load) begin
         sh_d   = hold_q;
         sig_d  = hold_q[DATA_W-1];
         bcnt_d = '0;
         full_d = 1'b0;
      end
      if (accept) begin
         hold_d = tx_data;
         full_d = 1'b1;
      end
   end

   always_ff @(posedge clk_300M or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         per_q    <= P_MIN;
         strobe_q <= 1'b0;
         sig_q    <= 1'b1;
         sh_q     <= '0;
         bcnt_q   <= '0;
         hold_q   <= '0;
         full_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         per_q    <= per_d;
         strobe_q <= wrap;
         sig_q    <= sig_d;
         sh_q     <= sh_d;
         bcnt_q   <= bcnt_d;
         hold_q   <= hold_d;
         full_q   <= full_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign tx_ready   = !full_q;
   assign signal     = sig_q;
   assign bit_strobe = strobe_q;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Directed bench for serial_bit_tx with a 4-bit preamble.
module tb_serial_bit_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] bit_period;
   logic        idle_toggle;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        signal;
   logic        bit_strobe;
   logic        busy;

   int n_total = 0;
   int n_bad   = 0;
   int busy_cnt;
   int rose;
   int bits[$];
   int sigs[$];
   int gaps[$];

   serial_bit_tx #(
      .DIV_LEN      (32),
      .DATA_W       (8),
      .PREAMBLE_BITS(4)
   ) dut (
      .clk_300M   (clk),
      .rst        (rst),
      .bit_period (bit_period),
      .idle_toggle(idle_toggle),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .signal     (signal),
      .bit_strobe (bit_strobe),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   task automatic to_strobe(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bit_strobe && n < 200);
      if (n >= 200) chk("strobe_timeout", n, 0);
   endtask

   task automatic observe(input int ncyc, input bit b2b);
      int last;
      bit drop;
      last = -1;
      drop = 1'b0;
      busy_cnt = 0;
      rose = 0;
      bits.delete();
      sigs.delete();
      gaps.delete();
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (!b2b) tx_valid = 1'b0;
         if (drop) begin
            tx_valid = 1'b0;
            drop = 1'b0;
         end
         if (busy) busy_cnt++;
         if (bit_strobe) begin
            sigs.push_back(int'(signal));
            gaps.push_back(c - last);
            last = c;
            if (busy) bits.push_back(int'(signal));
         end
         if (b2b && rose == 0 && tx_ready && busy) begin
            rose = 1;
            chk("ready_rise_at_load", bits.size(), 5);
         end
         if (b2b && tx_valid && tx_ready) drop = 1'b1;
      end
   endtask

   function automatic int bitq(input int i);
      if (i < bits.size()) return bits[i];
      return -1;
   endfunction

   initial begin
      int n, k, nb, exp_b;
      logic [7:0] a5;
      a5 = 8'hA5;
      rst = 1'b1;
      bit_period = 32'd4;
      idle_toggle = 1'b0;
      tx_valid = 1'b0;
      tx_data = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_signal", int'(signal), 1);
      chk("rst_ready", int'(tx_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_strobe", int'(bit_strobe), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("no_strobe_after_rel", int'(bit_strobe), 0);
      repeat (3) to_strobe(n);

      tx_data = 8'hA5;
      tx_valid = 1'b1;
      observe(70, 1'b0);
      chk("single_busy", busy_cnt, 48);
      chk("single_nbits", bits.size(), 12);
      for (int i = 0; i < 12; i++) begin
         exp_b = (i < 4) ? int'(i % 2 == 0) : int'(a5[11 - i]);
         chk($sformatf("single_bit%0d", i), bitq(i), exp_b);
      end
      nb = 0;
      for (int i = 1; i < gaps.size(); i++) if (gaps[i] != 4) nb++;
      chk("single_bit_len", nb, 0);
      chk("single_end_signal", int'(signal), 1);
      chk("single_end_busy", int'(busy), 0);

      to_strobe(n);
      repeat (3) @(negedge clk);
      tx_data = 8'h00;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      chk("wrap_accept_busy", int'(busy), 1);
      chk("wrap_accept_strobe", int'(bit_strobe), 1);
      chk("wrap_accept_signal", int'(signal), 1);
      observe(60, 1'b0);
      chk("wrap_rest_busy", busy_cnt, 47);
      chk("wrap_rest_nbits", bits.size(), 11);

      tx_data = 8'hFF;
      tx_valid = 1'b1;
      @(negedge clk);
      chk("ready_low_after_accept", int'(tx_ready), 0);
      tx_data = 8'h00;
      observe(100, 1'b1);
      chk("ready_rose", rose, 1);
      chk("b2b_busy", busy_cnt, 80);
      chk("b2b_nbits", bits.size(), 20);
      nb = 0;
      for (int i = 0; i < 20; i++) begin
         exp_b = (i < 4) ? int'(i % 2 == 0) : int'(i < 12);
         if (bitq(i) != exp_b) nb++;
      end
      chk("b2b_bits_wrong", nb, 0);
      chk("b2b_valid_dropped", int'(tx_valid), 0);

      idle_toggle = 1'b1;
      bit_period = 32'd5;
      observe(70, 1'b0);
      chk("idle_busy", busy_cnt, 0);
      chk("idle_enough", int'(sigs.size() >= 10), 1);
      nb = 0;
      for (int i = 1; i < gaps.size(); i++) if (gaps[i] != 5) nb++;
      chk("idle_period", nb, 0);
      nb = 0;
      for (int i = 1; i < sigs.size(); i++) if (sigs[i] == sigs[i-1]) nb++;
      chk("idle_alternate", nb, 0);

      bit_period = 32'd0;
      observe(30, 1'b0);
      chk("clamp_enough", int'(sigs.size() >= 10), 1);
      nb = 0;
      for (int i = 1; i < gaps.size(); i++) if (gaps[i] != 2) nb++;
      chk("clamp_period", nb, 0);
      to_strobe(n);
      bit_period = 32'd6;
      to_strobe(n);
      chk("change_cur_bit", n, 2);
      to_strobe(n);
      chk("change_next_bit", n, 6);

      idle_toggle = 1'b0;
      bit_period = 32'd4;
      repeat (3) to_strobe(n);
      tx_data = 8'h3C;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      n = 0;
      while (!tx_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rst_test_loaded", int'(tx_ready), 1);
      tx_data = 8'h81;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      chk("rst_test_buffered", int'(tx_ready), 0);
      k = 0;
      n = 0;
      while (k < 3 && n < 100) begin
         @(negedge clk);
         n++;
         if (bit_strobe) k++;
      end
      chk("bit3_busy", int'(busy), 1);
      chk("bit3_value", int'(signal), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_signal", int'(signal), 1);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_ready", int'(tx_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      observe(60, 1'b0);
      chk("post_rst_busy", busy_cnt, 0);
      nb = 0;
      foreach (sigs[i]) if (sigs[i] != 1) nb++;
      chk("post_rst_line_idle", nb, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
